// File: rtl/updown_count_pkg.sv
// Shared types and constants for the two-digit up/down count sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package updown_count_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Highest count value; the counter wraps here in both directions
    localparam int MAX_VAL_DEF = 99;

    // Active-low 7-segment codes, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/updown_count_ctrl_seg7_decode.sv
// BCD digit to active-low 7-segment code (gfedcba); non-decimal codes blank.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import updown_count_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Table lookup; anything above 9 blanks the display
    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// Load/run/pause/done sequencer for a 0..MAX_VAL up/down counter with BCD and 7-seg outputs.
// Latency: start -> LOAD next edge, count valid one edge later; first step TICK_DIV cycles into RUN.
// Backpressure: none; commands are single-cycle pulses acted on at the next edge.
module updown_count_ctrl
    import updown_count_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_VAL  = MAX_VAL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       ud,
    input  logic       auto_stop,
    input  logic [6:0] start_value,
    input  logic [6:0] stop_value,
    output logic [6:0] count,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic       running,
    output logic       done
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]      MAX_CNT    = 7'(MAX_VAL);

    state_t          state_q, state_d;
    logic [6:0]      count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [6:0]      step_val;

    // Value the counter moves to on a step, wrapping at 0 and MAX_VAL
    always_comb begin
        if (ud) begin
            step_val = (count_q == 7'd0) ? MAX_CNT : count_q - 7'd1;
        end else begin
            step_val = (count_q == MAX_CNT) ? 7'd0 : count_q + 7'd1;
        end
    end

    // Next-state logic: start always wins; a step finishes before pause/done take over
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = (start_value > MAX_CNT) ? MAX_CNT : start_value;
                presc_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = step_val;
                    if (auto_stop && (step_val == stop_value)) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end else if (pause) begin
                    // prescaler freezes at its current value
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else if (pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, counter, prescaler and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 7'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign digit1  = 4'(count_q / 7'd10);
    assign digit0  = 4'(count_q % 7'd10);

    seg7_decode u_seg0 (
        .bcd   (digit0),
        .seg_n (seg0)
    );

    seg7_decode u_seg1 (
        .bcd   (digit1),
        .seg_n (seg1)
    );

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized commands.
// Outputs are compared every falling edge against a wrap-around counter model.
// Inputs are driven on falling edges.
module tb_updown_count_ctrl;

    localparam int TICK = 4;
    localparam int MAXV = 99;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       reset, start, pause, ud, auto_stop;
    logic [6:0] start_value, stop_value;
    logic [6:0] count, seg0, seg1;
    logic [3:0] digit0, digit1;
    logic       running, done;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    // model state: mode, count, cycles left until the next step
    int  m_mode = M_IDLE;
    int  m_cnt  = 0;
    int  m_wait = TICK;
    bit  m_done = 1'b0;

    updown_count_ctrl #(.TICK_DIV(TICK), .MAX_VAL(MAXV)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .ud          (ud),
        .auto_stop   (auto_stop),
        .start_value (start_value),
        .stop_value  (stop_value),
        .count       (count),
        .digit0      (digit0),
        .digit1      (digit1),
        .seg0        (seg0),
        .seg1        (seg1),
        .running     (running),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model, advanced on each rising edge from the sampled inputs
    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_wait = TICK;
        end else begin
            case (m_mode)
                M_IDLE: if (start) m_mode = M_LOAD;
                M_LOAD: begin
                    m_cnt  = (int'(start_value) > MAXV) ? MAXV : int'(start_value);
                    m_wait = TICK;
                    m_mode = M_RUN;
                end
                M_RUN: begin
                    if (start) begin
                        m_mode = M_LOAD;
                    end else if (m_wait == 1) begin
                        m_wait = TICK;
                        m_cnt  = ud ? (m_cnt + MAXV) % (MAXV + 1) : (m_cnt + 1) % (MAXV + 1);
                        if (auto_stop && m_cnt == int'(stop_value)) begin
                            m_mode = M_DONE;
                            m_done = 1'b1;
                        end else if (pause) begin
                            m_mode = M_PAUSE;
                        end
                    end else if (pause) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_wait = m_wait - 1;
                    end
                end
                M_PAUSE: begin
                    if (start) m_mode = M_LOAD;
                    else if (pause) m_mode = M_RUN;
                end
                M_DONE: if (start) m_mode = M_LOAD;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",   count,   m_cnt);
            chk("digit0",  digit0,  m_cnt % 10);
            chk("digit1",  digit1,  m_cnt / 10);
            chk("seg0",    seg0,    seg_of(m_cnt % 10));
            chk("seg1",    seg1,    seg_of(m_cnt / 10));
            chk("running", running, (m_mode == M_RUN) ? 1 : 0);
            chk("done",    done,    m_done ? 1 : 0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        int exp_up[4];
        int exp_dn[4];
        exp_up = '{98, 99, 0, 1};
        exp_dn = '{1, 0, 99, 98};

        reset = 1'b1; start = 1'b0; pause = 1'b0; ud = 1'b0; auto_stop = 1'b0;
        start_value = 7'd0; stop_value = 7'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;

        // reset state after 20 idle cycles
        repeat (20) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_seg0", seg0, 7'b1000000);
        chk("rst_seg1", seg1, 7'b1000000);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);

        // up count through the 99 -> 0 wrap
        start_value = 7'd97;
        pulse_start();
        @(negedge clk);
        chk("up_load", count, 97);
        chk("model_up_load", m_cnt, 97);
        chk("up_running", running, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (TICK) @(negedge clk);
            chk("up_step", count, exp_up[i]);
            chk("model_up_step", m_cnt, exp_up[i]);
            if (i == 2) chk("wrap_seg1", seg1, 7'b1000000);
        end

        // down count with auto-stop at 98 after wrapping below 0
        start_value = 7'd2; ud = 1'b1; auto_stop = 1'b1; stop_value = 7'd98;
        pulse_start();
        @(negedge clk);
        chk("dn_load", count, 2);
        for (int i = 0; i < 4; i++) begin
            repeat (TICK) @(negedge clk);
            chk("dn_step", count, exp_dn[i]);
            chk("model_dn_step", m_cnt, exp_dn[i]);
        end
        chk("done_pulse", done, 1);
        chk("done_running", running, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        repeat (20) @(negedge clk);
        chk("done_hold", count, 98);
        chk("model_done_hold", m_cnt, 98);

        // pause two cycles into a step period, resume, step lands two cycles later
        start_value = 7'd10; ud = 1'b0; auto_stop = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("pz_load", count, 10);
        repeat (2) @(negedge clk);
        pulse_pause();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pz_hold", count, 10);
            chk("pz_running", running, 0);
        end
        pulse_pause();
        chk("pz_resume_run", running, 1);
        chk("pz_resume_cnt", count, 10);
        @(negedge clk);
        chk("pz_resume_1", count, 10);
        @(negedge clk);
        chk("pz_resume_2", count, 11);
        chk("model_pz_resume_2", m_cnt, 11);

        // start and pause together while paused: start wins
        start_value = 7'd40;
        pulse_start();
        @(negedge clk);
        chk("sp_load40", count, 40);
        pulse_pause();
        chk("sp_paused", running, 0);
        start_value = 7'd5;
        start = 1'b1; pause = 1'b1;
        @(negedge clk);
        start = 1'b0; pause = 1'b0;
        chk("sp_in_load", running, 0);
        chk("sp_cnt_hold", count, 40);
        @(negedge clk);
        chk("sp_cnt5", count, 5);
        chk("sp_running", running, 1);

        // clamp of an oversized start value, then reset mid-run
        start_value = 7'd120;
        pulse_start();
        @(negedge clk);
        chk("clamp", count, 99);
        chk("model_clamp", m_cnt, 99);
        start_value = 7'd50;
        pulse_start();
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("mid_run50", count, 50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_seg1", seg1, 7'b1000000);

        // randomized commands checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 14) == 0);
            reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 29) == 0) ud = ~ud;
            if ($urandom_range(0, 99) == 0) auto_stop = ~auto_stop;
            if ($urandom_range(0, 49) == 0) stop_value = 7'($urandom_range(0, 110));
            if (start) start_value = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        start = 1'b0; pause = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
Sequencer for the two-digit 0–99 up/down count datapath that drives the board's HEX1/HEX0 displays.
- Accepts load/run/pause commands and paces counting from a prescaled step tick.
- Optionally stops at a programmed terminal value and signals completion.
- Presents the count as BCD digits and active-low 7-segment codes for the top level.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count step (≥2; bench uses 4)
MAX_VAL, 99, highest count value; wrap boundary

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: load start_value and run
pause  in  1  one-cycle pulse: toggle RUN/PAUSE
ud  in  1  direction: 0 = up, 1 = down; sampled at each step
auto_stop  in  1  1 = stop when count reaches stop_value
start_value  in  7  value loaded on start
stop_value  in  7  terminal value for auto_stop
count  out  7  current count, binary 0..MAX_VAL
digit0  out  4  BCD ones digit of count
digit1  out  4  BCD tens digit of count
seg0  out  7  active-low 7-seg code for digit0, bit order gfedcba
seg1  out  7  active-low 7-seg code for digit1, bit order gfedcba
running  out  1  high while state is RUN
done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (synchronous, highest priority): state IDLE, count 0, prescaler 0, done 0, running 0, digits 0, seg0/seg1 = 7'b1000000 ("0").
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE; all transitions at clk edge.
- IDLE: count held. start -> LOAD; pause ignored.
- LOAD (exactly 1 cycle):
  - count <= start_value, clamped to MAX_VAL if start_value > MAX_VAL.
  - prescaler <= 0; next state RUN.
- Start latency: start sampled at edge k -> state LOAD after k; count = start_value and state RUN after k+1.
- RUN:
  - Prescaler increments each cycle; on reaching TICK_DIV-1 it returns to 0 and a step occurs. The first step is TICK_DIV cycles after entering RUN.
  - Step up: MAX_VAL -> 0, else +1. Step down: 0 -> MAX_VAL, else -1.
  - If auto_stop=1 and the post-step count == stop_value, next state is DONE and count holds the matched value.
  - pause -> PAUSE, prescaler frozen. start -> LOAD (restart).
- PAUSE: count and prescaler held. pause -> RUN, resuming the prescaler from its frozen value. start -> LOAD.
- DONE:
  - done=1 on the entry cycle only; count held.
  - start -> LOAD; all other inputs ignored; stays in DONE indefinitely.
- Simultaneous events:
  - start and pause in the same cycle: start wins.
  - Step and pause in the same cycle: the step completes, then PAUSE.
  - Step match and pause in the same cycle: DONE wins.
- auto_stop rules:
  - Compared only on steps. stop_value == start_value therefore requires a full lap (MAX_VAL+1 steps).
  - stop_value > MAX_VAL never matches; the counter free-runs.
- ud or auto_stop changes mid-run take effect at the next step; no restart.
- Reset mid-RUN/PAUSE: immediate return to the reset state on that edge; no done pulse.
- Digits and segments are combinational from count: digit1 = count/10, digit0 = count%10. Codes for 0–9 are standard; any digit >9 (unreachable) gives 7'b1111111 (blank).
- Prescaler width is $clog2(TICK_DIV); all arithmetic is unsigned, 7-bit for count.

Decomposition:
- Package updown_count_pkg:
  - state enum (IDLE, LOAD, RUN, PAUSE, DONE)
  - MAX_VAL default constant
  - SEG_BLANK and the 10 digit segment-code constants
- Sub-module seg7_decode (4-bit BCD in, 7-bit active-low out), instantiated twice.
- FSM, prescaler and count register stay in the top module.

Test Plan:
- Reset then idle 20 cycles -> count=0, seg0=seg1=7'b1000000, running=0, done=0.
- start_value=97, ud=0, auto_stop=0, start pulse (TICK_DIV=4) -> count 97 at k+1, then 98, 99, 0, 1 every 4 cycles; seg1 shows "0" after the wrap.
- start_value=2, ud=1, auto_stop=1, stop_value=98 -> count 2, 1, 0, 99, 98; done pulse for exactly 1 cycle; state DONE; count stays 98 for 20 cycles.
- Running from 10 up: pause 2 cycles into a step period, hold 10 cycles, pause again -> count stays 10 while paused; next step to 11 occurs 2 cycles after resume.
- start and pause in the same cycle while in PAUSE at count 40, start_value=5 -> LOAD then RUN; count=5; running=1.
- start_value=120 -> count clamps to 99; reset asserted mid-RUN at count 50 -> next edge count=0, IDLE, no done pulse.
